hazard_scoreboard: RTL and testbench

- Producer-side companion to the operand bypass network.
- Keeps a shadow copy of the in-flight register writes in the EXE, MEM and WB slots and compares them with the operand reads of the instruction in ID.
- Asserts id_stall whenever an operand's youngest producer has not yet computed its result, or its result will never be forwarded.
- Also maintains a saturating stall-cycle performance counter.
- Sits beside the ID stage; id_stall is ANDed into ID ready_go.

---
 rtl/hazard_scoreboard.sv | 143 ++++++++++++++
 tb/tb_hazard_scoreboard.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/hazard_scoreboard.sv
// Hazard scoreboard: shadows the register writes in flight in EXE/MEM/WB and
// stalls ID when an operand's youngest producer cannot forward its result yet.
module hazard_scoreboard #(
  parameter int WB_BYPASS = 0,
  parameter int CNT_W     = 32
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             id_go,
  input  logic [4:0]       id_dest,
  input  logic             id_we,
  input  logic [1:0]       id_kind,
  input  logic [4:0]       id_raddr1,
  input  logic             id_raddr1_en,
  input  logic [4:0]       id_raddr2,
  input  logic             id_raddr2_en,
  input  logic             id_valid,
  input  logic             exe_go,
  input  logic             mem_go,
  input  logic             wb_go,
  input  logic             flush,
  output logic             id_stall,
  output logic [CNT_W-1:0] stall_cnt
);

  typedef struct packed {
    logic       valid;
    logic       we;
    logic [4:0] dest;
    logic [1:0] kind;
  } slotT;

  localparam int StageExe = 0;
  localparam int StageMem = 1;
  localparam int StageWb  = 2;
  localparam int NumOps   = 2;

  slotT exeSlotReg, exeSlotNext;
  slotT memSlotReg, memSlotNext;
  slotT wbSlotReg, wbSlotNext;
  slotT issueSlot;

  logic [CNT_W-1:0] stallCntReg, stallCntNext;

  logic [4:0]        rdAddr [NumOps];
  logic [NumOps-1:0] rdEn;
  logic [NumOps-1:0] opStall;

  function automatic logic slotMatch(input slotT s, input logic [4:0] addr,
                                     input logic en);
    return s.valid && s.we && (s.dest == addr) && (addr != 5'd0) && en;
  endfunction

  // Kind 3 is reserved and behaves like kind 2 (result only at WB).
  function automatic logic slotStall(input logic [1:0] kind, input int stage);
    logic stallNow;
    stallNow = 1'b0;
    case (stage)
      StageExe: stallNow = (kind != 2'd0);
      StageMem: stallNow = kind[1];
      default:  stallNow = (WB_BYPASS == 0);
    endcase
    return stallNow;
  endfunction

  assign issueSlot = '{valid: 1'b1, we: id_we, dest: id_dest, kind: id_kind};

  // Each slot samples its predecessor's pre-edge contents, so a fully moving
  // pipeline shifts by one stage per edge.
  always_comb begin
    exeSlotNext = exeSlotReg;
    if (flush) begin
      exeSlotNext.valid = 1'b0;
    end else if (id_go) begin
      exeSlotNext = issueSlot;
    end else if (exe_go) begin
      exeSlotNext.valid = 1'b0;
    end
  end

  always_comb begin
    memSlotNext = memSlotReg;
    if (exe_go && !flush) begin
      memSlotNext = exeSlotReg;
    end else if (mem_go) begin
      memSlotNext.valid = 1'b0;
    end
  end

  always_comb begin
    wbSlotNext = wbSlotReg;
    if (mem_go) begin
      wbSlotNext = memSlotReg;
    end else if (wb_go) begin
      wbSlotNext.valid = 1'b0;
    end
  end

  assign rdAddr[0] = id_raddr1;
  assign rdAddr[1] = id_raddr2;
  assign rdEn      = {id_raddr2_en, id_raddr1_en};

  // Youngest matching slot alone decides, mirroring the bypass mux priority.
  genvar gi;
  generate
    for (gi = 0; gi < NumOps; gi++) begin : gOperand
      logic hitExe, hitMem, hitWb;
      assign hitExe = slotMatch(exeSlotReg, rdAddr[gi], rdEn[gi]);
      assign hitMem = slotMatch(memSlotReg, rdAddr[gi], rdEn[gi]);
      assign hitWb  = slotMatch(wbSlotReg, rdAddr[gi], rdEn[gi]);
      assign opStall[gi] = hitExe ? slotStall(exeSlotReg.kind, StageExe) :
                           hitMem ? slotStall(memSlotReg.kind, StageMem) :
                           hitWb  ? slotStall(wbSlotReg.kind, StageWb)   :
                                    1'b0;
    end
  endgenerate

  assign id_stall = id_valid && (|opStall);

  always_comb begin
    stallCntNext = stallCntReg;
    if (id_stall && (stallCntReg != {CNT_W{1'b1}})) begin
      stallCntNext = stallCntReg + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      exeSlotReg  <= '0;
      memSlotReg  <= '0;
      wbSlotReg   <= '0;
      stallCntReg <= '0;
    end else begin
      exeSlotReg  <= exeSlotNext;
      memSlotReg  <= memSlotNext;
      wbSlotReg   <= wbSlotNext;
      stallCntReg <= stallCntNext;
    end
  end

  assign stall_cnt = stallCntReg;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed bench for hazard_scoreboard: one instance without WB bypass and a
// 32-bit counter, one with WB bypass and a 4-bit counter, sharing stimulus.
module tb_hazard_scoreboard;

  logic       clk = 1'b0;
  logic       resetn;
  logic       id_go, id_we, id_raddr1_en, id_raddr2_en, id_valid;
  logic [4:0] id_dest, id_raddr1, id_raddr2;
  logic [1:0] id_kind;
  logic       exe_go, mem_go, wb_go, flush;

  logic        stall0, stall1;
  logic [31:0] cnt0;
  logic [3:0]  cnt1;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  hazard_scoreboard #(.WB_BYPASS(0), .CNT_W(32)) u_dut0 (
    .clk(clk), .resetn(resetn), .id_go(id_go), .id_dest(id_dest),
    .id_we(id_we), .id_kind(id_kind), .id_raddr1(id_raddr1),
    .id_raddr1_en(id_raddr1_en), .id_raddr2(id_raddr2),
    .id_raddr2_en(id_raddr2_en), .id_valid(id_valid), .exe_go(exe_go),
    .mem_go(mem_go), .wb_go(wb_go), .flush(flush), .id_stall(stall0),
    .stall_cnt(cnt0)
  );

  hazard_scoreboard #(.WB_BYPASS(1), .CNT_W(4)) u_dut1 (
    .clk(clk), .resetn(resetn), .id_go(id_go), .id_dest(id_dest),
    .id_we(id_we), .id_kind(id_kind), .id_raddr1(id_raddr1),
    .id_raddr1_en(id_raddr1_en), .id_raddr2(id_raddr2),
    .id_raddr2_en(id_raddr2_en), .id_valid(id_valid), .exe_go(exe_go),
    .mem_go(mem_go), .wb_go(wb_go), .flush(flush), .id_stall(stall1),
    .stall_cnt(cnt1)
  );

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic clr();
    id_go = 0; id_we = 0; id_dest = 0; id_kind = 0;
    id_raddr1 = 0; id_raddr1_en = 0; id_raddr2 = 0; id_raddr2_en = 0;
    id_valid = 0; exe_go = 0; mem_go = 0; wb_go = 0; flush = 0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [4:0] d, input logic [1:0] k);
    id_go = 1; id_we = 1; id_dest = d; id_kind = k;
  endtask

  task automatic allGo();
    exe_go = 1; mem_go = 1; wb_go = 1;
  endtask

  task automatic read1(input logic [4:0] a);
    id_valid = 1; id_raddr1 = a; id_raddr1_en = 1;
  endtask

  task automatic doReset(input string tag);
    clr();
    resetn = 0;
    #1;
    check({tag, "_rst_stall0"}, 32'(stall0), 0);
    check({tag, "_rst_cnt0"}, cnt0, 0);
    tick();
    resetn = 1;
    #1;
  endtask

  initial begin
    clr();
    resetn = 1;
    #2;

    // ALU -> ALU: dependent read right behind an ALU producer never stalls.
    doReset("alu");
    issue(5'd5, 2'd0); allGo(); id_valid = 1; #1;
    check("alu_issue_stall0", 32'(stall0), 0);
    tick(); clr();
    read1(5'd5); id_go = 1; allGo(); #1;
    check("alu_exe_stall0", 32'(stall0), 0);
    check("alu_exe_stall1", 32'(stall1), 0);
    tick(); clr();
    check("alu_cnt0", cnt0, 0);

    // Load-use: one stall cycle while the load moves EXE -> MEM.
    doReset("ld");
    issue(5'd7, 2'd1); allGo(); tick(); clr();
    read1(5'd7); allGo(); #1;
    check("ld_exe_stall0", 32'(stall0), 1);
    check("ld_exe_stall1", 32'(stall1), 1);
    tick(); clr();
    read1(5'd7); id_go = 1; allGo(); #1;
    check("ld_mem_stall0", 32'(stall0), 0);
    check("ld_mem_stall1", 32'(stall1), 0);
    tick(); clr(); #1;
    check("ld_cnt0", cnt0, 1);
    check("ld_cnt1", 32'(cnt1), 1);

    // WB-only producer: stalls through WB without bypass, until WB with it.
    doReset("wbo");
    issue(5'd3, 2'd2); allGo(); tick(); clr();
    read1(5'd3); allGo(); #1;
    check("wbo_exe_stall0", 32'(stall0), 1);
    check("wbo_exe_stall1", 32'(stall1), 1);
    tick(); clr();
    read1(5'd3); allGo(); #1;
    check("wbo_mem_stall0", 32'(stall0), 1);
    check("wbo_mem_stall1", 32'(stall1), 1);
    tick(); clr();
    read1(5'd3); allGo(); #1;
    check("wbo_wb_stall0", 32'(stall0), 1);
    check("wbo_wb_stall1", 32'(stall1), 0);
    tick(); clr();
    read1(5'd3); #1;
    check("wbo_done_stall0", 32'(stall0), 0);
    check("wbo_cnt0", cnt0, 3);
    check("wbo_cnt1", 32'(cnt1), 2);

    // Youngest wins: ALU r4 in EXE hides the load r4 in MEM.
    doReset("yw");
    issue(5'd4, 2'd1); allGo(); tick(); clr();
    issue(5'd4, 2'd0); allGo(); tick(); clr();
    read1(5'd4); #1;
    check("yw_exe_stall0", 32'(stall0), 0);
    check("yw_exe_stall1", 32'(stall1), 0);
    tick(); clr();
    exe_go = 1; mem_go = 1; tick(); clr();
    read1(5'd4); #1;
    check("yw_mem_stall0", 32'(stall0), 0);

    // r0 never matches; disabled operand does not stall, enabled one does.
    doReset("r0");
    issue(5'd0, 2'd1); allGo(); tick(); clr();
    read1(5'd0); issue(5'd9, 2'd1); allGo(); #1;
    check("r0_stall0", 32'(stall0), 0);
    tick(); clr();
    id_valid = 1; id_raddr1 = 5'd9; id_raddr1_en = 0;
    id_raddr2 = 5'd0; id_raddr2_en = 1; #1;
    check("dis_stall0", 32'(stall0), 0);
    id_raddr2 = 5'd9; #1;
    check("op2_en_stall0", 32'(stall0), 1);
    clr(); #1;

    // Flush with exe_go discards the load; flush also kills a same-cycle issue.
    doReset("fl");
    issue(5'd2, 2'd1); allGo(); tick(); clr();
    id_raddr1 = 5'd2; id_raddr1_en = 1; flush = 1; allGo(); #1;
    check("fl_novalid_stall0", 32'(stall0), 0);
    tick(); clr();
    read1(5'd2); #1;
    check("fl_after_stall0", 32'(stall0), 0);
    check("fl_after_stall1", 32'(stall1), 0);
    clr(); issue(5'd2, 2'd1); flush = 1; tick(); clr();
    read1(5'd2); #1;
    check("fl_issue_stall0", 32'(stall0), 0);
    tick(); clr();
    check("fl_cnt0", cnt0, 0);

    // Asynchronous reset in the middle of a stall.
    doReset("ar");
    issue(5'd7, 2'd1); tick(); clr();
    read1(5'd7); #1;
    check("ar_pre_stall0", 32'(stall0), 1);
    tick(); tick();
    check("ar_pre_cnt0", cnt0, 2);
    resetn = 0; #1;
    check("ar_stall0", 32'(stall0), 0);
    check("ar_stall1", 32'(stall1), 0);
    check("ar_cnt0", cnt0, 0);
    check("ar_cnt1", 32'(cnt1), 0);
    #2 resetn = 1; #1;
    check("ar_rel_stall0", 32'(stall0), 0);
    tick();
    check("ar_post_stall0", 32'(stall0), 0);
    check("ar_post_cnt0", cnt0, 0);
    clr();

    // Saturation: the 4-bit counter sticks at 15, the 32-bit one keeps going.
    doReset("sat");
    issue(5'd7, 2'd1); tick(); clr();
    read1(5'd7);
    for (int i = 0; i < 15; i++) tick();
    check("sat15_cnt1", 32'(cnt1), 15);
    check("sat15_cnt0", cnt0, 15);
    for (int i = 0; i < 5; i++) tick();
    check("sat20_cnt1", 32'(cnt1), 15);
    check("sat20_cnt0", cnt0, 20);
    clr();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
